sysid_checker: RTL and testbench

//  Avalon-MM read master; the initiator side of the 2-word system-ID slave (word 0 = ID, word 1 = timestamp).

---
 rtl/sysid_checker.sv | 153 +++++++++++++++
 tb/tb_sysid_checker.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the 2-word system ID (ID, timestamp) and
// compares both words against build-time constants, latching values and pass/fail/timeout flags.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | quiescent; waits for start (or the one-shot auto start)
// S_REQ_ID  | read asserted at word 0 until accepted
// S_WAIT_ID | waiting for readdatavalid carrying the ID word
// S_REQ_TS  | read asserted at word 1 until accepted
// S_WAIT_TS | waiting for readdatavalid carrying the timestamp word
// S_FIN     | one-cycle done pulse, then back to idle
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1408928828,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int            CW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_ID,
        S_WAIT_ID,
        S_REQ_TS,
        S_WAIT_TS,
        S_FIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          auto_pend;
    logic          tmo_hit;
    logic          launch;
    logic          in_xfer;

    always_comb begin
        state_nxt   = state;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        done        = 1'b0;
        tmo_hit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start || auto_pend) state_nxt = S_REQ_ID;
            end
            S_REQ_ID: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    state_nxt = S_WAIT_ID;
                end else if (cnt >= TC_LAST) begin
                    state_nxt = S_FIN;
                    tmo_hit   = 1'b1;
                end
            end
            S_WAIT_ID: begin
                if (avm_readdatavalid) begin
                    state_nxt = S_REQ_TS;
                end else if (cnt >= TC_LAST) begin
                    state_nxt = S_FIN;
                    tmo_hit   = 1'b1;
                end
            end
            S_REQ_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                if (!avm_waitrequest) begin
                    state_nxt = S_WAIT_TS;
                end else if (cnt >= TC_LAST) begin
                    state_nxt = S_FIN;
                    tmo_hit   = 1'b1;
                end
            end
            S_WAIT_TS: begin
                if (avm_readdatavalid) begin
                    state_nxt = S_FIN;
                end else if (cnt >= TC_LAST) begin
                    state_nxt = S_FIN;
                    tmo_hit   = 1'b1;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign launch  = (state == S_IDLE) && (state_nxt == S_REQ_ID);
    assign in_xfer = (state != S_IDLE) && (state != S_FIN);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            auto_pend <= AUTO_START;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            state <= state_nxt;

            // The counter restarts for each word so every transaction gets the full budget.
            if ((state_nxt != state) && (state_nxt == S_REQ_ID || state_nxt == S_REQ_TS)) begin
                cnt <= '0;
            end else if (in_xfer) begin
                cnt <= cnt + 1'b1;
            end

            if (launch) begin
                auto_pend <= 1'b0;
                id_ok     <= 1'b0;
                ts_ok     <= 1'b0;
                timeout   <= 1'b0;
                id_value  <= '0;
                ts_value  <= '0;
            end

            if (state == S_WAIT_ID && avm_readdatavalid) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (state == S_WAIT_TS && avm_readdatavalid) begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TS);
            end
            if (tmo_hit) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: a latency-1 Avalon slave model plus scoreboard queues
// of expected read addresses and expected end-of-check results.
module tb_sysid_checker;

    localparam logic [31:0] GOOD_ID = 32'h0000_0000;
    localparam logic [31:0] GOOD_TS = 32'd1408928828;

    logic        clock;
    logic        reset_n;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic        start;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    sysid_checker #(
        .EXPECTED_ID   (GOOD_ID),
        .EXPECTED_TS   (GOOD_TS),
        .TIMEOUT_CYCLES(8),
        .AUTO_START    (1'b1)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata     (avm_readdata),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .id_ok            (id_ok),
        .ts_ok            (ts_ok),
        .timeout          (timeout),
        .id_value         (id_value),
        .ts_value         (ts_value)
    );

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] idv;
        logic [31:0] tsv;
    } exp_t;

    exp_t exp_q[$];
    logic addr_q[$];

    int checks = 0;
    int errors = 0;

    // slave model controls
    logic [31:0] slv_id;
    logic [31:0] slv_ts;
    int          slv_wait;
    logic        slv_respond;

    int read_cycles = 0;
    int dones = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic i, input logic t, input logic o,
                                input logic [31:0] iv, input logic [31:0] tv);
        exp_t e;
        e.id_ok = i; e.ts_ok = t; e.tmo = o; e.idv = iv; e.tsv = tv;
        return e;
    endfunction

    // Slave: waitrequest for slv_wait cycles per request, data one cycle after acceptance.
    initial begin
        logic        pend;
        logic [31:0] pend_data;
        logic        held_addr;
        int          wait_cnt;
        pend = 1'b0; pend_data = '0; held_addr = 1'b0; wait_cnt = 0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        forever begin
            @(negedge clock);
            if (pend) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = pend_data;
                pend              = 1'b0;
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata      = 32'hDEAD_BEEF;
            end
            if (avm_read === 1'b1) begin
                if (wait_cnt > 0) chk("addr_hold", avm_address, held_addr);
                else held_addr = avm_address;
                if (wait_cnt < slv_wait) begin
                    avm_waitrequest = 1'b1;
                    wait_cnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    wait_cnt = 0;
                    chk("accept_expected", addr_q.size() != 0, 1);
                    if (addr_q.size() != 0) chk("read_addr", avm_address, addr_q.pop_front());
                    pend      = slv_respond;
                    pend_data = avm_address ? slv_ts : slv_id;
                end
            end else begin
                avm_waitrequest = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (avm_read === 1'b1) read_cycles++;
            if (done === 1'b1) dones++;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock); #1;
            lat++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("exp_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("id_ok", id_ok, e.id_ok);
                chk("ts_ok", ts_ok, e.ts_ok);
                chk("timeout", timeout, e.tmo);
                chk("id_value", id_value, e.idv);
                chk("ts_value", ts_value, e.tsv);
                chk("busy_in_fin", busy, 1);
            end
        end
    endtask

    task automatic after_done();
        @(posedge clock); #1;
        chk("done_one_cycle", done, 0);
        chk("busy_cleared", busy, 0);
        chk("read_idle", avm_read, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}, 0);
        chk(tag, id_value, 0);
        chk(tag, ts_value, 0);
    endtask

    initial begin
        int  lat;
        bit  found;
        reset_n = 1'b0;
        start = 1'b0;
        slv_id = GOOD_ID; slv_ts = GOOD_TS; slv_wait = 0; slv_respond = 1'b1;

        // 1: auto start after reset, good slave
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset_zero");
        exp_q.push_back(mk(1, 1, 0, GOOD_ID, GOOD_TS));
        addr_q.push_back(1'b0); addr_q.push_back(1'b1);
        read_cycles = 0;
        reset_n = 1'b1;
        wait_done(lat);
        chk("auto_read_cycles", read_cycles, 2);
        after_done();
        repeat (2) @(posedge clock);
        #1;
        chk("sticky_flags", {id_ok, ts_ok, timeout}, 3'b110);

        // 2: wrong ID
        slv_id = 32'h1;
        exp_q.push_back(mk(0, 1, 0, 32'h1, GOOD_TS));
        addr_q.push_back(1'b0); addr_q.push_back(1'b1);
        dones = 0;
        pulse_start();
        wait_done(lat);
        after_done();
        repeat (3) @(posedge clock);
        #1;
        chk("single_done", dones, 1);

        // 3: five waitrequest cycles per request
        slv_id = GOOD_ID; slv_wait = 5;
        exp_q.push_back(mk(1, 1, 0, GOOD_ID, GOOD_TS));
        addr_q.push_back(1'b0); addr_q.push_back(1'b1);
        read_cycles = 0;
        pulse_start();
        wait_done(lat);
        chk("stall_read_cycles", read_cycles, 12);
        after_done();

        // 4a: request never accepted -> read held exactly the timeout budget
        slv_wait = 1000;
        exp_q.push_back(mk(0, 0, 1, 0, 0));
        read_cycles = 0;
        pulse_start();
        wait_done(lat);
        chk("tmo_read_cycles", read_cycles, 8);
        after_done();

        // 4b: ID accepted but no data ever returns -> timestamp never requested
        slv_wait = 0; slv_respond = 1'b0;
        exp_q.push_back(mk(0, 0, 1, 0, 0));
        addr_q.push_back(1'b0);
        pulse_start();
        wait_done(lat);
        after_done();
        repeat (3) @(posedge clock);
        #1;
        chk("tmo_no_ts_read", addr_q.size(), 0);
        slv_respond = 1'b1;

        // 5: reset in WAIT_TS while readdatavalid arrives
        slv_id = 32'hA5; slv_ts = 32'h1234;
        addr_q.push_back(1'b0); addr_q.push_back(1'b1);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (avm_read === 1'b1 && avm_address === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("ts_request_seen", found, 1);
        @(posedge clock);
        @(negedge clock);
        chk("pre_reset_id", id_value, 32'hA5);
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk_all_zero("mid_reset_zero");
        @(posedge clock); #1;
        chk_all_zero("mid_reset_hold");
        slv_id = GOOD_ID; slv_ts = GOOD_TS;
        exp_q.push_back(mk(1, 1, 0, GOOD_ID, GOOD_TS));
        addr_q.push_back(1'b0); addr_q.push_back(1'b1);
        reset_n = 1'b1;
        wait_done(lat);
        after_done();

        // 6: start while busy ignored, start in FIN ignored, start one cycle later honoured
        slv_id = 32'h1;
        exp_q.push_back(mk(0, 1, 0, 32'h1, GOOD_TS));
        addr_q.push_back(1'b0); addr_q.push_back(1'b1);
        dones = 0;
        pulse_start();
        @(posedge clock); #1;
        pulse_start();
        wait_done(lat);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("start_in_fin_ignored", busy, 0);
        chk("busy_start_ignored", dones, 1);
        slv_id = GOOD_ID;
        exp_q.push_back(mk(1, 1, 0, GOOD_ID, GOOD_TS));
        addr_q.push_back(1'b0); addr_q.push_back(1'b1);
        pulse_start();
        chk("restart_busy", busy, 1);
        chk("restart_clears", {id_ok, ts_ok, timeout}, 0);
        chk("restart_clears_id", id_value, 0);
        wait_done(lat);
        chk("latency", lat, 4);
        after_done();

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", exp_q.size() + addr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
